// File: rtl/doodle_frame_sequencer.sv
// Frame-level sequencer for the doodle-jump core: divides the clock into
// frames, latches the buttons once per frame and steps the datapath through
// physics -> collision -> render, with done/timeout handshakes.
module doodle_frame_sequencer #(
    parameter int FRAME_CYCLES = 50,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        left,
    input  logic        right,
    input  logic        collideDone,
    input  logic        renderDone,
    output logic        moveLeft,
    output logic        moveRight,
    output logic        physicsUpdate,
    output logic        collideReq,
    output logic        renderReq,
    output logic [15:0] frameCount,
    output logic        overrun,
    output logic        timeoutErr,
    output logic [2:0]  state
);

    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        PHYS    = 3'd2,
        COLLIDE = 3'd3,
        RENDER  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          left_seen_q, right_seen_q;
    logic          move_left_q, move_left_d;
    logic          move_right_q, move_right_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          overrun_q;
    logic          timeout_q, timeout_d;

    logic frame_tick;
    logic wait_hit;

    assign frame_tick = (tick_cnt_q == TW'(FRAME_CYCLES - 1));
    // The exit edge is the TIMEOUT-th edge spent waiting.
    assign wait_hit   = (wait_cnt_q == 8'(TIMEOUT - 1));

    // Free-running frame timer and button latches (a press wins over the SAMPLE clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            left_seen_q  <= 1'b0;
            right_seen_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            tick_cnt_q   <= frame_tick ? '0 : tick_cnt_q + 1'b1;
            left_seen_q  <= left  | (left_seen_q  & (state_q != SAMPLE));
            right_seen_q <= right | (right_seen_q & (state_q != SAMPLE));
            // A tick outside IDLE is dropped; remember that it happened.
            if (frame_tick && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    // FSM state and per-frame registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            frame_cnt_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            frame_cnt_q  <= frame_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic and Moore decodes of the phase strobes/requests.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        move_left_d   = move_left_q;
        move_right_d  = move_right_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_d     = timeout_q;
        physicsUpdate = 1'b0;
        collideReq    = 1'b0;
        renderReq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick) state_d = SAMPLE;
            end
            SAMPLE: begin
                // Conflicting presses cancel each other.
                move_left_d  = left_seen_q & ~right_seen_q;
                move_right_d = right_seen_q & ~left_seen_q;
                state_d      = PHYS;
            end
            PHYS: begin
                physicsUpdate = 1'b1;
                wait_cnt_d    = '0;
                state_d       = COLLIDE;
            end
            COLLIDE: begin
                collideReq = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (collideDone || wait_hit) begin
                    if (!collideDone) timeout_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = RENDER;
                end
            end
            RENDER: begin
                renderReq  = 1'b1;
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (renderDone || wait_hit) begin
                    if (!renderDone) timeout_d = 1'b1;
                    wait_cnt_d  = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign moveLeft   = move_left_q;
    assign moveRight  = move_right_q;
    assign frameCount = frame_cnt_q;
    assign overrun    = overrun_q;
    assign timeoutErr = timeout_q;
    assign state      = state_q;

endmodule

// File: tb/tb_doodle_frame_sequencer.sv
// Scoreboard bench for doodle_frame_sequencer (FRAME_CYCLES=8, TIMEOUT=16).
// Cycle numbers count rising edges since the last reset release.
module tb_doodle_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        left = 1'b0, right = 1'b0;
    logic        collideDone = 1'b1, renderDone = 1'b1;
    logic        moveLeft, moveRight, physicsUpdate, collideReq, renderReq;
    logic [15:0] frameCount;
    logic        overrun, timeoutErr;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    int cyc;

    typedef struct packed {
        logic        kind;   // 0 = physics strobe, 1 = frame completed
        logic [31:0] cyc;
        logic        ml;
        logic        mr;
        logic [15:0] fc;
        logic        ovr;
        logic        tmo;
    } ev_t;

    ev_t sb[$];

    doodle_frame_sequencer #(.FRAME_CYCLES(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(rst), .left(left), .right(right),
        .collideDone(collideDone), .renderDone(renderDone),
        .moveLeft(moveLeft), .moveRight(moveRight), .physicsUpdate(physicsUpdate),
        .collideReq(collideReq), .renderReq(renderReq), .frameCount(frameCount),
        .overrun(overrun), .timeoutErr(timeoutErr), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic k, input int c, input logic ml, input logic mr,
                        input int fc, input logic ovr, input logic tmo);
        ev_t e;
        e.kind = k; e.cyc = c; e.ml = ml; e.mr = mr; e.fc = 16'(fc); e.ovr = ovr; e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic take(input logic k);
        ev_t a, e;
        a.kind = k; a.cyc = cyc; a.ml = moveLeft; a.mr = moveRight;
        a.fc = frameCount; a.ovr = overrun; a.tmo = timeoutErr;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind=%0d cyc=%0d fc=%0d", k, cyc, frameCount);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d ml=%0d mr=%0d fc=%0d ovr=%0d tmo=%0d expected kind=%0d cyc=%0d ml=%0d mr=%0d fc=%0d ovr=%0d tmo=%0d",
                         a.kind, a.cyc, a.ml, a.mr, a.fc, a.ovr, a.tmo,
                         e.kind, e.cyc, e.ml, e.mr, e.fc, e.ovr, e.tmo);
            end
        end
    endtask

    // Monitor: any physics strobe or frame-count change pops the scoreboard.
    initial begin
        logic [15:0] prev_fc;
        prev_fc = '0;
        forever begin
            @(negedge clk);
            if (rst) prev_fc = '0;
            else begin
                if (physicsUpdate === 1'b1) take(1'b0);
                if (frameCount !== prev_fc) take(1'b1);
                prev_fc = frameCount;
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_outs"}, {moveLeft, moveRight, physicsUpdate, collideReq, renderReq, overrun, timeoutErr}, 0);
        chk({tag, "_fc"}, frameCount, 0);
        chk({tag, "_state"}, state, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_reset_outs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Free-running frames, short presses, slow collision, timeout, left press before reset.
        push(0,   9, 0, 0, 0, 0, 0);  push(1,  12, 0, 0, 1, 0, 0);
        push(0,  17, 1, 0, 1, 0, 0);  push(1,  20, 1, 0, 2, 0, 0);
        push(0,  25, 0, 0, 2, 0, 0);  push(1,  28, 0, 0, 3, 0, 0);
        push(0,  33, 0, 0, 3, 0, 0);  push(1,  36, 0, 0, 4, 0, 0);
        push(0,  41, 0, 1, 4, 0, 0);  push(1,  44, 0, 1, 5, 0, 0);
        push(0,  49, 0, 0, 5, 0, 0);  push(1,  63, 0, 0, 6, 1, 0);
        push(0,  65, 0, 0, 6, 1, 0);  push(1,  68, 0, 0, 7, 1, 0);
        push(0,  73, 0, 0, 7, 1, 0);  push(1,  91, 0, 0, 8, 1, 1);
        push(0,  97, 0, 0, 8, 1, 1);  push(1, 100, 0, 0, 9, 1, 1);
        push(0, 105, 1, 0, 9, 1, 1);

        at(13); left = 1'b1;  at(14); left = 1'b0;               // single-cycle left
        at(28); left = 1'b1;  at(29); left = 1'b0;               // both in one frame
        at(30); right = 1'b1; at(31); right = 1'b0;
        at(37); right = 1'b1; at(38); right = 1'b0;              // right only

        at(46); collideDone = 1'b0;                              // slow collision
        at(55);
        chk("slow_req", {collideReq, renderReq}, 2'b10);
        chk("slow_ovr_pre", overrun, 0);
        at(56);
        chk("slow_ovr_set", overrun, 1);
        chk("slow_req2", {collideReq, renderReq}, 2'b10);
        at(61); collideDone = 1'b1;

        at(70); collideDone = 1'b0;                              // stuck collision
        at(89);
        chk("tmo_pre", {collideReq, renderReq, timeoutErr}, 3'b100);
        at(90);
        chk("tmo_hit", {collideReq, renderReq, timeoutErr}, 3'b011);
        at(91); collideDone = 1'b1;

        at(100); left = 1'b1; at(101); left = 1'b0;
        at(102); renderDone = 1'b0;                              // park in RENDER
        at(108);
        chk("mid_render_state", state, 4);
        chk("mid_render_ml", moveLeft, 1);
        chk("sb_empty_before_reset", sb.size(), 0);
        #1 rst = 1'b1;
        #1 chk_reset_outs("async_reset");
        renderDone = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push(0, 9, 0, 0, 0, 0, 0);  push(1, 12, 0, 0, 1, 0, 0);
        at(14);
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
